// File: rtl/fp32_pkg.sv
// fp32_pkg
// Shared definitions for the single-precision floating-point units:
// format constants and an unpacked-operand structure.
package fp32_pkg;

    localparam int          FP_BIAS    = 127;
    localparam int          FP_EXP_MAX = 255;
    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [7:0]  FP_INF_EXP = 8'hFF;

    // Field view of an IEEE-754 single-precision word.
    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

endpackage : fp32_pkg

// File: rtl/fp_mant_div.sv
// fp_mant_div
// Combinational restoring divider for 24-bit normalized mantissas.
// Produces 26 quotient bits of dividend/divisor, scaled so that
// o_quot = floor(dividend * 2^25 / divisor), plus a sticky bit that is
// set when the final remainder is non-zero.
//
// Ports:
//   i_dividend  in  24  {1, fraction} of the dividend
//   i_divisor   in  24  {1, fraction} of the divisor
//   o_quot      out 26  quotient bits, MSB = integer bit
//   o_sticky    out 1   remainder != 0
module fp_mant_div (
    input  logic [23:0] i_dividend,
    input  logic [23:0] i_divisor,
    output logic [25:0] o_quot,
    output logic        o_sticky
);

    // One stage per quotient bit. Each remainder is strictly below the
    // divisor, so 24 bits hold it; the shifted partial needs 25.
    generate
        for (genvar gi = 0; gi < 26; gi++) begin : g_step
            logic [24:0] w_part;
            logic        w_q;
            logic [23:0] w_rem;

            if (gi == 0) begin : g_first
                // First step compares the unshifted dividend: integer bit.
                assign w_part = {1'b0, i_dividend};
            end else begin : g_next
                assign w_part = {g_step[gi-1].w_rem, 1'b0};
            end

            assign w_q   = (w_part >= {1'b0, i_divisor});
            assign w_rem = w_q ? 24'(w_part - {1'b0, i_divisor}) : w_part[23:0];
            assign o_quot[25-gi] = w_q;
        end
    endgenerate

    assign o_sticky = |g_step[25].w_rem;

endmodule : fp_mant_div

// File: rtl/floating_division.sv
// floating_division
// Single-precision IEEE-754 divider, result = A / B, round-to-nearest-even,
// flush-to-zero on subnormal inputs and outputs. Fully combinational
// datapath into one output register captured when EN is high.
//
// Ports:
//   clk     in  1   rising-edge clock
//   rst_n   in  1   asynchronous active-low reset, clears result
//   EN      in  1   capture enable
//   A       in  32  dividend
//   B       in  32  divisor
//   result  out 32  registered quotient
module floating_division
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        EN,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] result
);

    fp32_t       w_a;
    fp32_t       w_b;
    logic        w_sign;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [25:0] w_quot;
    logic        w_rem_sticky;
    logic [31:0] w_result_next;
    logic [31:0] r_result;

    assign w_a    = fp32_t'(A);
    assign w_b    = fp32_t'(B);
    assign w_sign = w_a.sign ^ w_b.sign;

    assign w_a_nan  = (w_a.exp == FP_INF_EXP) && (w_a.frac != '0);
    assign w_b_nan  = (w_b.exp == FP_INF_EXP) && (w_b.frac != '0);
    assign w_a_inf  = (w_a.exp == FP_INF_EXP) && (w_a.frac == '0);
    assign w_b_inf  = (w_b.exp == FP_INF_EXP) && (w_b.frac == '0);
    // exp==0 covers both true zero and subnormals (flushed to zero).
    assign w_a_zero = (w_a.exp == 8'd0);
    assign w_b_zero = (w_b.exp == 8'd0);

    fp_mant_div u_mant_div (
        .i_dividend (({1'b1, w_a.frac})),
        .i_divisor  (({1'b1, w_b.frac})),
        .o_quot     (w_quot),
        .o_sticky   (w_rem_sticky)
    );

    logic signed [9:0] w_exp_raw;
    logic signed [9:0] w_exp_norm;
    logic signed [9:0] w_exp_fin;
    logic [23:0]       w_mant_pre;
    logic              w_guard;
    logic              w_sticky;
    logic              w_round_up;
    logic [24:0]       w_mant_rnd;
    logic [22:0]       w_frac_fin;

    assign w_exp_raw = $signed({2'b00, w_a.exp}) - $signed({2'b00, w_b.exp})
                       + 10'(FP_BIAS);

    always_comb begin
        w_mant_pre = '0;
        w_guard    = 1'b0;
        w_sticky   = 1'b0;
        w_exp_norm = w_exp_raw;
        w_exp_fin  = w_exp_raw;
        w_frac_fin = '0;

        // Quotient in (0.5, 2): MSB clear means one left shift is needed.
        if (w_quot[25]) begin
            w_mant_pre = w_quot[25:2];
            w_guard    = w_quot[1];
            w_sticky   = w_quot[0] | w_rem_sticky;
            w_exp_norm = w_exp_raw;
        end else begin
            w_mant_pre = w_quot[24:1];
            w_guard    = w_quot[0];
            w_sticky   = w_rem_sticky;
            w_exp_norm = w_exp_raw - 10'sd1;
        end

        w_round_up = w_guard & (w_sticky | w_mant_pre[0]);
        w_mant_rnd = {1'b0, w_mant_pre} + {24'd0, w_round_up};

        // Rounding carry-out: mantissa becomes 1.0, exponent bumps.
        if (w_mant_rnd[24]) begin
            w_frac_fin = w_mant_rnd[23:1];
            w_exp_fin  = w_exp_norm + 10'sd1;
        end else begin
            w_frac_fin = w_mant_rnd[22:0];
            w_exp_fin  = w_exp_norm;
        end
    end

    always_comb begin
        w_result_next = '0;
        if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
            w_result_next = FP_QNAN;
        end else if (w_a_inf || w_b_zero) begin
            w_result_next = {w_sign, FP_INF_EXP, 23'd0};
        end else if (w_a_zero || w_b_inf) begin
            w_result_next = {w_sign, 31'd0};
        end else if (w_exp_fin >= 10'(FP_EXP_MAX)) begin
            w_result_next = {w_sign, FP_INF_EXP, 23'd0};
        end else if (w_exp_fin <= 10'sd0) begin
            w_result_next = {w_sign, 31'd0};
        end else begin
            w_result_next = {w_sign, w_exp_fin[7:0], w_frac_fin};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
        end else if (EN) begin
            r_result <= w_result_next;
        end
    end

    assign result = r_result;

endmodule : floating_division

// File: tb/tb_floating_division.sv
// tb_floating_division
// Directed-vector self-checking bench for floating_division.
module tb_floating_division;

    logic        clk;
    logic        rst_n;
    logic        EN;
    logic [31:0] A;
    logic [31:0] B;
    logic [31:0] result;

    int n_checks;
    int n_fail;

    floating_division dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .EN     (EN),
        .A      (A),
        .B      (B),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // One enabled divide: drive at negedge, sample 1 ns after the capture edge.
    task automatic do_div(input string tag, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        @(negedge clk);
        A  = a;
        B  = b;
        EN = 1'b1;
        @(posedge clk);
        #1;
        $display("op %-10s A=%08h B=%08h result=%08h expected=%08h",
                 tag, a, b, result, exp);
        check_val(tag, result, exp);
    endtask

    logic [31:0] held;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        EN       = 1'b1;
        A        = 32'h3F80_0000;
        B        = 32'h3F80_0000;

        // Reset holds result at zero even with EN high over clock edges.
        repeat (2) @(posedge clk);
        #1;
        check_val("reset", result, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;

        do_div("normal",   32'h411C_0000, 32'h4080_0000, 32'h401C_0000);
        do_div("zero_a",   32'h0000_0000, 32'h411C_0000, 32'h0000_0000);
        do_div("inf_a",    32'h7F80_0000, 32'h411C_0000, 32'h7F80_0000);
        do_div("neg_div1", 32'h41B2_6666, 32'hBF00_0000, 32'hC232_6666);
        do_div("neg_div2", 32'hC0CC_CCCC, 32'hBF00_0000, 32'h414C_CCCC);
        do_div("neg_div3", 32'h40CC_CCCC, 32'hBF00_0000, 32'hC14C_CCCC);
        // 0.66/0.51: fraction 2467237 remainder well under half -> round down
        do_div("round",    32'h3F28_F5C2, 32'h3F02_8F5C, 32'h3FA5_A5A5);
        // 1/3: quotient below 1 (shift path), guard=1 sticky=1 -> round up
        do_div("third",    32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB);
        do_div("div_zero", 32'h3FA6_6666, 32'h0000_0000, 32'h7F80_0000);
        do_div("neg_by_0", 32'h3F80_0000, 32'h8000_0000, 32'hFF80_0000);
        do_div("zero_0",   32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000);
        do_div("inf_inf",  32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000);
        do_div("nan_in",   32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000);
        do_div("ninf_a",   32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000);
        do_div("by_inf",   32'h3F80_0000, 32'h7F80_0000, 32'h0000_0000);
        do_div("negzero",  32'h8000_0000, 32'h3F80_0000, 32'h8000_0000);
        do_div("subnorm",  32'h0000_0001, 32'h3F80_0000, 32'h0000_0000);
        do_div("overflow", 32'h7F7F_FFFF, 32'h0080_0000, 32'h7F80_0000);
        do_div("underflw", 32'h0080_0000, 32'h7F7F_FFFF, 32'h0000_0000);
        do_div("negovf",   32'hFF7F_FFFF, 32'h0080_0000, 32'hFF80_0000);

        // EN low: new operands must not reach the register.
        do_div("pre_hold", 32'h411C_0000, 32'h4080_0000, 32'h401C_0000);
        held = 32'h401C_0000;
        @(negedge clk);
        EN = 1'b0;
        A  = 32'h7F80_0000;
        B  = 32'h3F80_0000;
        repeat (3) @(posedge clk);
        #1;
        $display("op %-10s EN=0 result=%08h expected=%08h", "hold", result, held);
        check_val("hold", result, held);

        // Asynchronous reset mid-cycle clears result without a clock edge.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("op %-10s rst_n=0 result=%08h expected=%08h", "async_rst", result, 32'h0);
        check_val("async_rst", result, 32'h0000_0000);
        @(negedge clk);
        rst_n = 1'b1;

        // First enabled edge after release yields a valid quotient.
        do_div("post_rst", 32'h41B2_6666, 32'hBF00_0000, 32'hC232_6666);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule : tb_floating_division
